// File: rtl/ecc_36_wr_enc.sv
// ecc_36_wr_enc: write-side SEC-DED encoder for 36-bit words, 7 check bits.
// A registered output stage plus a one-entry skid buffer gives a valid/ready
// pipeline with latency 1 and full throughput. An optional error-injection
// FSM corrupts one accepted word after its check bits have been computed.
// Optional feature macro: ECC_ERR_INJ_EN (injection logic compiled only when defined).
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  upstream raw word handshake
//   m_valid/m_ready         downstream handshake
//   m_data/m_parity         stored data and check bits (possibly corrupted)
//   inj_arm/inj_dbl         arm pulse, single/double select
//   inj_pos0/inj_pos1       flip positions (0-35 data, 36-42 parity, 43-63 none)
//   inj_busy                injection armed but not yet applied
//   word_cnt                words delivered downstream (wraps)
module ecc_36_wr_enc #(
    parameter int unsigned DATA_WIDTH   = 36,
    parameter int unsigned PARITY_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic [PARITY_WIDTH-1:0] m_parity,
    input  logic                    inj_arm,
    input  logic                    inj_dbl,
    input  logic [5:0]              inj_pos0,
    input  logic [5:0]              inj_pos1,
    output logic                    inj_busy,
    output logic [15:0]             word_cnt
);

    localparam int unsigned WORD_W = DATA_WIDTH + PARITY_WIDTH;

    // Data bit i carries the i-th non-power-of-two code in 3..42; parity[k]
    // covers codes with bit k set, parity[6] covers even-popcount codes.
    function automatic logic [PARITY_WIDTH-1:0] f_parity(input logic [DATA_WIDTH-1:0] d);
        logic [PARITY_WIDTH-1:0] p;
        logic [5:0]              code;
        logic [5:0]              idx;
        p   = '0;
        idx = '0;
        for (int unsigned v = 3; v <= 42; v++) begin
            code = 6'(v);
            if ((code & (code - 6'd1)) != 6'd0) begin
                p[5:0] = p[5:0] ^ (code & {6{d[idx]}});
                p[6]   = p[6] ^ (d[idx] & ~(^code));
                idx    = idx + 6'd1;
            end
        end
        return p;
    endfunction

    // One-hot flip mask over {parity, data}; positions past the word shift out to zero.
    function automatic logic [WORD_W-1:0] f_mask(input logic [5:0] pos);
        return WORD_W'(1) << pos;
    endfunction

    logic                  r_m_valid;
    logic [WORD_W-1:0]     r_m_word;
    logic                  r_skid_valid;
    logic [WORD_W-1:0]     r_skid_word;
    logic                  r_s_ready;
    logic [15:0]           r_word_cnt;

    logic                  w_accept;
    logic                  w_out_free;
    logic                  w_skid_valid_nxt;
    logic [WORD_W-1:0]     w_flip;
    logic [WORD_W-1:0]     w_word;

    assign w_accept   = s_valid & r_s_ready;
    assign w_out_free = ~r_m_valid | m_ready;
    assign w_word     = {f_parity(s_data), s_data} ^ w_flip;

`ifdef ECC_ERR_INJ_EN
    typedef enum logic {ST_IDLE, ST_ARMED} inj_state_t;

    inj_state_t  r_inj_state;
    logic        r_inj_busy;
    logic        r_dbl;
    logic [5:0]  r_pos0;
    logic [5:0]  r_pos1;

    logic        w_dbl;
    logic [5:0]  w_pos0;
    logic [5:0]  w_pos1;
    logic        w_inj_now;

    // A fresh arm pulse overrides the latched fields in the same cycle.
    assign w_dbl     = inj_arm ? inj_dbl  : r_dbl;
    assign w_pos0    = inj_arm ? inj_pos0 : r_pos0;
    assign w_pos1    = inj_arm ? inj_pos1 : r_pos1;
    assign w_inj_now = w_accept & (inj_arm | (r_inj_state == ST_ARMED));
    // Equal double positions cancel through the XOR.
    assign w_flip    = w_inj_now ? (f_mask(w_pos0) ^ (w_dbl ? f_mask(w_pos1) : '0)) : '0;
    assign inj_busy  = r_inj_busy;

    // Injection FSM: arm, then fire on the next accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inj_state <= ST_IDLE;
            r_inj_busy  <= 1'b0;
            r_dbl       <= 1'b0;
            r_pos0      <= '0;
            r_pos1      <= '0;
        end else begin
            if (inj_arm) begin
                r_dbl  <= inj_dbl;
                r_pos0 <= inj_pos0;
                r_pos1 <= inj_pos1;
            end
            if (w_inj_now) begin
                r_inj_state <= ST_IDLE;
                r_inj_busy  <= 1'b0;
            end else if (inj_arm) begin
                r_inj_state <= ST_ARMED;
                r_inj_busy  <= 1'b1;
            end
        end
    end
`else
    logic w_unused_inj;
    assign w_unused_inj = ^{inj_arm, inj_dbl, inj_pos0, inj_pos1};
    assign w_flip       = '0;
    assign inj_busy     = 1'b0;
`endif

    // Skid holds a word only when it was accepted while the output stalled.
    always_comb begin
        w_skid_valid_nxt = 1'b0;
        if (r_skid_valid) begin
            w_skid_valid_nxt = ~w_out_free;
        end else begin
            w_skid_valid_nxt = w_accept & ~w_out_free;
        end
    end

    // Output stage, skid buffer, ready and delivered-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid    <= 1'b0;
            r_m_word     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_word  <= '0;
            r_s_ready    <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_word  <= r_skid_word;
                end else if (w_accept) begin
                    r_m_valid <= 1'b1;
                    r_m_word  <= w_word;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
            if (w_accept && !w_out_free) begin
                r_skid_word <= w_word;
            end
            r_skid_valid <= w_skid_valid_nxt;
            r_s_ready    <= ~w_skid_valid_nxt;
            if (r_m_valid && m_ready) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_word[DATA_WIDTH-1:0];
    assign m_parity = r_m_word[WORD_W-1:DATA_WIDTH];
    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_ecc_36_wr_enc.sv
// Self-checking bench for ecc_36_wr_enc: constant parity table, directed
// stream/stall/injection/reset sequences and a randomized phase, all checked
// against a code-table reference model and an output scoreboard.
module tb_ecc_36_wr_enc;

`ifdef ECC_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [35:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [35:0] m_data;
    logic [6:0]  m_parity;
    logic        inj_arm;
    logic        inj_dbl;
    logic [5:0]  inj_pos0;
    logic [5:0]  inj_pos1;
    logic        inj_busy;
    logic [15:0] word_cnt;

    ecc_36_wr_enc #(.DATA_WIDTH(36), .PARITY_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_parity(m_parity),
        .inj_arm(inj_arm), .inj_dbl(inj_dbl), .inj_pos0(inj_pos0), .inj_pos1(inj_pos1),
        .inj_busy(inj_busy), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: code of data bit i, then check bits as XOR of codes.
    function automatic int code_of(input int i);
        int n = 0;
        for (int v = 3; v <= 42; v++) begin
            if ($countones(v) != 1) begin
                if (n == i) return v;
                n++;
            end
        end
        return 0;
    endfunction

    function automatic logic [42:0] enc(input logic [35:0] d);
        logic [6:0] p = '0;
        int c;
        for (int i = 0; i < 36; i++) begin
            if (d[i]) begin
                c = code_of(i);
                p[5:0] = p[5:0] ^ 6'(c);
                if ($countones(c) % 2 == 0) p[6] = ~p[6];
            end
        end
        return {p, d};
    endfunction

    function automatic logic [42:0] flip(input logic [42:0] w, input int pos);
        if (pos < 43) w[pos] = ~w[pos];
        return w;
    endfunction

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // Scoreboard / injection model, evaluated on the falling edge.
    logic [42:0] q[$];
    bit          md_armed;
    bit          md_dbl;
    int          md_p0, md_p1;
    int          exp_cnt;
    bit          prev_stall;
    logic [42:0] prev_word;

    always @(negedge clk) begin
        logic [42:0] w;
        if (!rst_n) begin
            q.delete();
            md_armed   = 1'b0;
            exp_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            chk("inj_busy", inj_busy, md_armed);
            chk("word_cnt", word_cnt, 64'(exp_cnt));
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_word", {m_parity, m_data}, prev_word);
            end
            if (m_valid && m_ready) begin
                chk("out_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    w = q.pop_front();
                    chk("out_word", {m_parity, m_data}, w);
                end
                exp_cnt = (exp_cnt + 1) & 16'hFFFF;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_parity, m_data};
            if (INJ && inj_arm) begin
                md_dbl = inj_dbl;
                md_p0  = int'(inj_pos0);
                md_p1  = int'(inj_pos1);
            end
            if (s_valid && s_ready) begin
                w = enc(s_data);
                if (INJ && (inj_arm || md_armed)) begin
                    w = flip(w, md_p0);
                    if (md_dbl) w = flip(w, md_p1);
                    md_armed = 1'b0;
                end
                q.push_back(w);
            end else if (INJ && inj_arm) begin
                md_armed = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic arm(input bit dbl, input int p0, input int p1);
        inj_arm  = 1'b1;
        inj_dbl  = dbl;
        inj_pos0 = 6'(p0);
        inj_pos1 = 6'(p1);
        tick();
        inj_arm  = 1'b0;
    endtask

    task automatic send_one(input logic [35:0] d, output logic [42:0] got);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        @(negedge clk);
        got = {m_parity, m_data};
    endtask

    task automatic drain();
        int n = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        while ((q.size() != 0 || m_valid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < 50, 1);
        chk("drain_queue_empty", q.size(), 0);
    endtask

    typedef struct {
        logic [35:0] d;
        logic [6:0]  p;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[6];
        logic [42:0] got;
        int          acc_cnt, mv_cnt;
        bit          acc;

        tbl[0] = '{36'h000000001, 7'h43};
        tbl[1] = '{36'h800000000, 7'h2A};
        tbl[2] = '{36'h000000000, 7'h00};
        tbl[3] = '{36'h000000002, 7'h45};
        tbl[4] = '{36'h000000003, 7'h06};
        tbl[5] = '{36'h000000004, 7'h46};

        rst_n = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        inj_arm = 1'b0; inj_dbl = 1'b0; inj_pos0 = '0; inj_pos1 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_parity", m_parity, 0);
        chk("rst_inj_busy", inj_busy, 0);
        chk("rst_word_cnt", word_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("s_ready_before_edge", s_ready, 0);
        tick();
        chk("s_ready_after_edge", s_ready, 1);
        chk("m_valid_after_edge", m_valid, 0);

        // Constant parity table, latency 1.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_one(tbl[i].d, got);
            chk("tbl_m_valid", m_valid, 1);
            chk("tbl_m_parity", got[42:36], tbl[i].p);
            chk("tbl_m_data", got[35:0], tbl[i].d);
            tick();
        end
        drain();

        // 100 back-to-back words.
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        acc_cnt = 0;
        mv_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
            s_data = rnd36();
            @(negedge clk);
            acc_cnt += int'(s_valid && s_ready);
            mv_cnt  += int'(m_valid);
            tick();
        end
        s_valid = 1'b0;
        @(negedge clk);
        mv_cnt += int'(m_valid);
        chk("stream_accepted", acc_cnt, 100);
        chk("stream_no_gaps", mv_cnt, 100);
        tick();
        @(negedge clk);
        chk("stream_idle", m_valid, 0);
        chk("stream_word_cnt", word_cnt, 100);

        // Downstream stall of 5 cycles under continuous valid.
        tick();
        s_valid = 1'b1;
        s_data  = rnd36();
        for (int c = 0; c < 13; c++) begin
            m_ready = !(c >= 3 && c < 8);
            @(negedge clk);
            if (c == 3) chk("stall_ready_first", s_ready, 1);
            if (c >= 4 && c < 8) chk("stall_ready_low", s_ready, 0);
            acc = s_valid && s_ready;
            tick();
            if (acc) s_data = rnd36();
        end
        drain();

        // Injection directed cases.
        arm(1'b0, 5, 0);
        @(negedge clk);
        chk("single_busy", inj_busy, INJ);
        send_one(36'h0, got);
        chk("single_word", got, INJ ? {7'h00, 36'h000000020} : 43'h0);
        chk("single_busy_clr", inj_busy, 0);
        send_one(36'h0, got);
        chk("after_single_clean", got, 0);

        tick();
        arm(1'b1, 0, 40);
        send_one(36'h0, got);
        chk("double_word", got, INJ ? {7'h10, 36'h000000001} : 43'h0);
        tick();
        arm(1'b1, 7, 7);
        send_one(36'h0, got);
        chk("double_cancel", got, 0);
        tick();
        arm(1'b0, 50, 0);
        send_one(36'h0, got);
        chk("pos_none", got, 0);
        tick();
        arm(1'b0, 3, 0);
        arm(1'b0, 9, 0);
        send_one(36'h0, got);
        chk("relatch", got, INJ ? 43'h200 : 43'h0);
        tick();
        arm(1'b0, 1, 0);
        inj_arm = 1'b1; inj_pos0 = 6'd38; inj_dbl = 1'b0;
        s_valid = 1'b1; s_data = 36'h0;
        tick();
        inj_arm = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("arm_with_accept", {m_parity, m_data}, INJ ? {7'h04, 36'h0} : 43'h0);
        chk("arm_with_accept_busy", inj_busy, 0);
        tick();
        drain();

        // Randomized traffic with injections.
        s_valid = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            if (!s_valid || acc) begin
                s_valid = ($urandom % 4) != 0;
                s_data  = rnd36();
            end
            m_ready  = ($urandom % 4) != 0;
            inj_arm  = ($urandom % 16) == 0;
            inj_dbl  = 1'($urandom);
            inj_pos0 = 6'($urandom_range(63, 0));
            inj_pos1 = 6'($urandom_range(63, 0));
        end
        inj_arm = 1'b0;
        tick();
        drain();

        // Reset during stall with an injection armed.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = rnd36();
        tick();
        s_data  = rnd36();
        tick();
        s_valid = 1'b0;
        arm(1'b0, 4, 0);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_busy", inj_busy, INJ);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_parity", m_parity, 0);
        chk("mid_rst_inj_busy", inj_busy, 0);
        chk("mid_rst_word_cnt", word_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("post_rst_ready", s_ready, 1);
        @(negedge clk);
        chk("post_rst_idle", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
